timer_compare: RTL and testbench
================================

TIMER_COMPARE -- requirements
Module: timer_compare

Interface
REQ-001 SHALL have parameter ResetCmp, default 64'hFFFF_FFFF_FFFF_FFFF, initial 64-bit compare value.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port time_lo  in  32  low word of the 64-bit time value from the system timer.
REQ-005 SHALL have port time_hi  in  32  high word of the 64-bit time value from the system timer.
REQ-006 SHALL have port wr_en  in  1  CSR write strobe to the compare register, one cycle per write.
REQ-007 SHALL have port wr_hi  in  1  write target: 1 selects the high word, 0 selects the low word.
REQ-008 SHALL have port wr_data  in  32  write data.
REQ-009 SHALL have port rd_hi  in  1  read word select.
REQ-010 SHALL have port rd_data  out  32  compare word selected by rd_hi, combinational.
REQ-011 SHALL have port mtie  in  1  machine timer interrupt enable.
REQ-012 SHALL have port mtip  out  1  timer pending status, unmasked.
REQ-013 SHALL have port irq  out  1  interrupt request to the trap unit, equal to mtip AND mtie.

Function
REQ-014 SHALL hold a 64-bit compare register cmp, split into cmp_lo and cmp_hi.
REQ-015 SHALL register ge_q = ({time_hi,time_lo} >= cmp), unsigned 64-bit, every cycle.
REQ-016 SHALL force ge_q to 0 in any cycle with wr_en=1, so a stale comparison is discarded.
REQ-017 SHALL implement FSM states ARMED, HALF, PENDING.
REQ-018 ARMED: a low-word write -> HALF; a high-word write -> ARMED; ge_q=1 with no write -> PENDING.
REQ-019 HALF: a high-word write -> ARMED; a low-word write -> HALF; ge_q is ignored, so a partial update never fires.
REQ-020 PENDING: a low-word write -> HALF; a high-word write -> ARMED; otherwise stay in PENDING (level-held, no auto-clear).
REQ-021 SHALL drive mtip=1 only in PENDING.
REQ-022 SHALL give a latency of 2 edges: time first >= cmp at sampling edge k gives ge_q=1 after edge k and mtip=1 after edge k+1.
REQ-023 SHALL treat cmp equal to time as firing (>= comparison, not >).
REQ-024 Wrap-around: time wrapping past 2^64-1 to 0 SHALL cause no event; once PENDING, the state holds until a write.
REQ-025 SHALL take effect the cycle after the write edge; rd_data shows the new word on the following cycle.
REQ-026 mtie SHALL mask irq only; it SHALL NOT change FSM state or mtip.
REQ-027 A time step of more than 1 per cycle SHALL still fire, because the comparison is >= and not equality.

Reset
REQ-028 With rst=1 at an edge: cmp=ResetCmp, ge_q=0, state=ARMED, mtip=0, irq=0.
REQ-029 A reset during HALF or PENDING SHALL return to ARMED with cmp=ResetCmp; a wr_en in the same cycle SHALL be ignored.
REQ-030 Outputs SHALL be valid the first cycle after reset deasserts.

Structure
REQ-031 SHALL place the state enum (ARMED, HALF, PENDING) and the CMP_LO/CMP_HI select constants in the shared SysTimerConsts package.
REQ-032 SHALL use the codebase's IntReg type for the 32-bit words.
REQ-033 MAY isolate the registered 64-bit comparator as sub-module timer_cmp_ge; the FSM and register file SHALL stay in timer_compare.

Verification
REQ-034 Reset: rst high 2 cycles -> rd_data=FFFF_FFFF for both words; mtip=0 with time=0.
REQ-035 Basic fire: write lo=0x10, then hi=0; ramp time from 0 -> mtip rises 2 edges after time=0x10 is sampled; irq=1 only while mtie=1.
REQ-036 Half-write guard: in PENDING, write lo=0 -> state HALF, mtip=0 even though time >= 0; hold for 5 cycles with no fire; write hi=0 -> fires 2 edges later.
REQ-037 Clear by rewrite: in PENDING, write hi=0xFFFF_FFFF -> mtip=0 next cycle and stays 0.
REQ-038 Carry boundary: cmp=0x1_0000_0000, time steps 0x0_FFFF_FFFF -> 0x1_0000_0000 -> mtip rises at the required latency and not one cycle early.
REQ-039 Simultaneous: wr_en in the same cycle ge_q would assert -> no fire; reset asserted alongside wr_en -> cmp=ResetCmp.

Source files
------------

// File: rtl/timer_compare_pkg.sv
// Shared constants and types for the system-timer compare block.
package SysTimerConsts;

    typedef logic [31:0] IntReg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        HALF    = 2'd1,
        PENDING = 2'd2
    } timer_state_e;

    localparam logic CMP_LO = 1'b0;
    localparam logic CMP_HI = 1'b1;

    function automatic IntReg cmp_word_sel(input logic sel, input IntReg lo, input IntReg hi);
        return (sel == CMP_HI) ? hi : lo;
    endfunction

endpackage

// File: rtl/timer_cmp_ge.sv
// Registered unsigned 64-bit time >= compare; a flush discards the result.
module timer_cmp_ge
    import SysTimerConsts::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] time_val,
    input  logic [63:0] cmp_val,
    input  logic        flush,
    output logic        ge_q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ge_q <= 1'b0;
        end else begin
            ge_q <= (time_val >= cmp_val);
        end
    end

endmodule

// File: rtl/timer_compare.sv
// Machine timer compare register with a half-write guard and level-held pending.
module timer_compare
    import SysTimerConsts::*;
#(
    parameter logic [63:0] ResetCmp = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_lo,
    input  logic [31:0] time_hi,
    input  logic        wr_en,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic        rd_hi,
    output logic [31:0] rd_data,
    input  logic        mtie,
    output logic        mtip,
    output logic        irq
);

    IntReg        cmp_lo;
    IntReg        cmp_hi;
    timer_state_e state;
    logic         mtip_q;
    logic         ge_q;
    logic         wr_lo_w;
    logic         wr_hi_w;

    assign wr_lo_w = wr_en && (wr_hi == CMP_LO);
    assign wr_hi_w = wr_en && (wr_hi == CMP_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_lo <= ResetCmp[31:0];
            cmp_hi <= ResetCmp[63:32];
        end else if (wr_lo_w) begin
            cmp_lo <= wr_data;
        end else if (wr_hi_w) begin
            cmp_hi <= wr_data;
        end
    end

    // Any write flushes the comparator so a result against the old value never lands.
    timer_cmp_ge u_cmp_ge (
        .clk      (clk),
        .rst      (rst),
        .time_val ({time_hi, time_lo}),
        .cmp_val  ({cmp_hi, cmp_lo}),
        .flush    (wr_en),
        .ge_q     (ge_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARMED;
            mtip_q <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (wr_lo_w) begin
                        state  <= HALF;
                        mtip_q <= 1'b0;
                    end else if (!wr_en && ge_q) begin
                        state  <= PENDING;
                        mtip_q <= 1'b1;
                    end
                end
                // Only the high-word write re-arms; the comparison is not trusted mid-update.
                HALF: begin
                    mtip_q <= 1'b0;
                    if (wr_hi_w) begin
                        state <= ARMED;
                    end
                end
                PENDING: begin
                    if (wr_lo_w) begin
                        state  <= HALF;
                        mtip_q <= 1'b0;
                    end else if (wr_hi_w) begin
                        state  <= ARMED;
                        mtip_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ARMED;
                    mtip_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = cmp_word_sel(rd_hi, cmp_lo, cmp_hi);
    assign mtip    = mtip_q;
    assign irq     = mtip_q & mtie;

endmodule

// File: tb/tb_timer_compare.sv
module tb_timer_compare;

    logic        clk;
    logic        rst;
    logic [31:0] time_lo;
    logic [31:0] time_hi;
    logic        wr_en;
    logic        wr_hi;
    logic [31:0] wr_data;
    logic        rd_hi;
    logic [31:0] rd_data;
    logic        mtie;
    logic        mtip;
    logic        irq;

    typedef struct {
        logic mtip;
        logic irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_compare dut (
        .clk     (clk),
        .rst     (rst),
        .time_lo (time_lo),
        .time_hi (time_hi),
        .wr_en   (wr_en),
        .wr_hi   (wr_hi),
        .wr_data (wr_data),
        .rd_hi   (rd_hi),
        .rd_data (rd_data),
        .mtie    (mtie),
        .mtip    (mtip),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [63:0] t);
        {time_hi, time_lo} = t;
    endtask

    task automatic do_write(input logic hi, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_hi   = hi;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_hi = 1'b0; wr_data = '0;
        rd_hi = 1'b0; mtie = 1'b1; set_time(64'd0);
        tick(); tick();
        rst = 1'b0;
        rd_hi = 1'b0; #1;
        n_checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL reset_rd_lo: got %h expected ffffffff", rd_data);
        end
        rd_hi = 1'b1; #1;
        n_checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL reset_rd_hi: got %h expected ffffffff", rd_data);
        end
        n_checks++;
        if (mtip !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: mtip=%b irq=%b expected 0 0", mtip, irq);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL reset_idle: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    task automatic test_basic();
        mtie = 1'b0;
        do_write(1'b0, 32'h10);
        rd_hi = 1'b0; #1;
        n_checks++;
        if (rd_data !== 32'h10) begin
            n_fail++; $display("FAIL basic_rd_lo: got %h expected 00000010", rd_data);
        end
        do_write(1'b1, 32'h0);
        rd_hi = 1'b1; #1;
        n_checks++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL basic_rd_hi: got %h expected 00000000", rd_data);
        end
        // time 0x10 is sampled at step 16, so mtip is expected from step 17
        for (int i = 0; i < 25; i++) begin
            set_time(64'(i));
            mtie = (i >= 20);
            exp_q.push_back('{mtip: (i >= 17), irq: (i >= 20)});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL basic_ramp[%0d]: mtip=%b irq=%b expected %b %b", i, mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    task automatic test_half_guard();
        set_time(64'd25);
        exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
        do_write(1'b0, 32'h0);
        got = exp_q.pop_front();
        n_checks++;
        if (mtip !== got.mtip || irq !== got.irq) begin
            n_fail++; $display("FAIL half_enter: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
        end
        for (int j = 0; j < 5; j++) begin
            set_time(64'(26 + j));
            exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL half_hold[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
        exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
        do_write(1'b1, 32'h0);
        got = exp_q.pop_front();
        n_checks++;
        if (mtip !== got.mtip || irq !== got.irq) begin
            n_fail++; $display("FAIL half_rearm: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
        end
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back('{mtip: (j >= 1), irq: (j >= 1)});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL half_fire[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    task automatic test_clear();
        exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
        do_write(1'b1, 32'hFFFF_FFFF);
        got = exp_q.pop_front();
        n_checks++;
        if (mtip !== got.mtip || irq !== got.irq) begin
            n_fail++; $display("FAIL clear_write: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
        end
        for (int j = 0; j < 5; j++) begin
            set_time(64'(40 + j));
            exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL clear_hold[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    task automatic test_carry_wrap();
        logic [63:0] tv [8];
        logic        em [8];
        tv = '{64'h0_FFFF_FFFE, 64'h0_FFFF_FFFF, 64'h1_0000_0000, 64'h1_0000_0001,
               64'h1_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7};
        em = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_write(1'b0, 32'h0);
        do_write(1'b1, 32'h1);
        for (int j = 0; j < 8; j++) begin
            set_time(tv[j]);
            exp_q.push_back('{mtip: em[j], irq: em[j]});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL carry_wrap[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
        for (int j = 0; j < 4; j++) begin
            mtie = j[0];
            exp_q.push_back('{mtip: 1'b1, irq: j[0]});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL mtie_mask[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
        mtie = 1'b1;
    endtask

    task automatic test_big_step();
        set_time(64'd0);
        do_write(1'b0, 32'h100);
        do_write(1'b1, 32'h0);
        set_time(64'h1000);
        for (int j = 0; j < 3; j++) begin
            exp_q.push_back('{mtip: (j >= 1), irq: (j >= 1)});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL big_step[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    task automatic test_simultaneous();
        // reset from PENDING with a competing write
        rst = 1'b1; wr_en = 1'b1; wr_hi = 1'b0; wr_data = 32'h1234;
        exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
        tick();
        rst = 1'b0; wr_en = 1'b0;
        got = exp_q.pop_front();
        n_checks++;
        if (mtip !== got.mtip || irq !== got.irq) begin
            n_fail++; $display("FAIL rst_wr_out: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
        end
        rd_hi = 1'b0; #1;
        n_checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rst_wr_rd_lo: got %h expected ffffffff", rd_data);
        end
        rd_hi = 1'b1; #1;
        n_checks++;
        if (rd_data !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rst_wr_rd_hi: got %h expected ffffffff", rd_data);
        end
        set_time(64'd0);
        do_write(1'b0, 32'h50);
        do_write(1'b1, 32'h0);
        set_time(64'h4F);
        tick();
        set_time(64'h50);
        exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
        do_write(1'b1, 32'hFFFF_FFFF);
        got = exp_q.pop_front();
        n_checks++;
        if (mtip !== got.mtip || irq !== got.irq) begin
            n_fail++; $display("FAIL simul_edge: mtip=%b irq=%b expected %b %b", mtip, irq, got.mtip, got.irq);
        end
        set_time(64'h60);
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back('{mtip: 1'b0, irq: 1'b0});
            tick();
            got = exp_q.pop_front();
            n_checks++;
            if (mtip !== got.mtip || irq !== got.irq) begin
                n_fail++; $display("FAIL simul_hold[%0d]: mtip=%b irq=%b expected %b %b", j, mtip, irq, got.mtip, got.irq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_half_guard();
        test_clear();
        test_carry_wrap();
        test_big_step();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
